// File: rtl/lut_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_config_loader
// Brief    : Assembles packed stream words into full fracturable-LUT configs
//            and commits them one LUT at a time via one-hot config enables.
// Revision : 1.0 - initial release
// ============================================================================
module lut_config_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int CFG_W    = 2*MEM_SIZE + 1,
    parameter int NUM_LUTS = 4,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CFG_W-1:0]    config_out,
    output logic [NUM_LUTS-1:0] cen_out,
    output logic                busy,
    output logic                done
);

    localparam int WPL   = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(WPL - 1);
    localparam logic [IDX_W-1:0] C_LAST_LUT  = IDX_W'(NUM_LUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [IDX_W-1:0]   r_lut_idx;
    logic [CFG_W-1:0]   r_asm;
    logic [CFG_W-1:0]   w_asm_next;
    logic               w_accept;
    logic               w_last_word;
    logic               w_last_lut;

    assign w_accept    = (r_state == S_LOAD) && in_valid;
    assign w_last_word = (r_word_cnt == C_LAST_WORD);
    assign w_last_lut  = (r_lut_idx == C_LAST_LUT);
    assign config_out  = r_asm;

    // Each config bit takes its stream bit only when its own word is current;
    // final-word bits beyond CFG_W have no destination and simply drop.
    for (genvar i = 0; i < CFG_W; i++) begin : g_bit
        localparam int K = i / WORD_W;
        localparam int B = i % WORD_W;
        assign w_asm_next[i] = (r_word_cnt == CNT_W'(K)) ? in_data[B] : r_asm[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cen_out  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_last_word) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                busy    = 1'b1;
                cen_out = NUM_LUTS'(1) << r_lut_idx;
                w_next  = w_last_lut ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_lut_idx  <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word_cnt <= '0;
                        r_lut_idx  <= '0;
                        r_asm      <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_asm      <= w_asm_next;
                        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_word_cnt <= '0;
                    if (!w_last_lut) begin
                        r_lut_idx <= r_lut_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_config_loader
// Brief    : Randomised scoreboard bench for lut_config_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_config_loader;

    localparam int CFG_W = 33;
    localparam int NL    = 4;
    localparam int WW    = 8;
    localparam int WPL   = 5;

    typedef struct packed {
        logic [NL-1:0]    cen;
        logic [CFG_W-1:0] cfg;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CFG_W-1:0] config_out;
    logic [NL-1:0]    cen_out;
    logic             busy;
    logic             done;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   done_cnt  = 0;
    int   done_k    = 0;
    int   commit_k[$];
    exp_t exp_q[$];

    lut_config_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .config_out (config_out),
        .cen_out    (cen_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    // Reference: LUT g's config is words 5g..5g+4 laid LSB-first, truncated to CFG_W.
    function automatic logic [CFG_W-1:0] model(input logic [WW-1:0] w[$], input int g);
        logic [WPL*WW-1:0] acc;
        acc = '0;
        for (int j = 0; j < WPL; j++) acc[j*WW +: WW] = w[g*WPL + j];
        return acc[CFG_W-1:0];
    endfunction

    // Monitor: every commit pulse pops one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (cen_out != '0) begin
                exp_t e;
                commit_k.push_back(cyc - start_cyc + 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit cen_out=%b config_out=%h expected no commit",
                             cen_out, config_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_cen", 64'(cen_out), 64'(e.cen));
                    chk("commit_cfg", 64'(config_out), 64'(e.cfg));
                    chk("commit_busy", 64'(busy), 64'd1);
                    chk("commit_ready", 64'(in_ready), 64'd0);
                end
            end
            if (done) begin
                done_cnt++;
                done_k = cyc - start_cyc + 1;
                chk("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    task automatic start_seq();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        commit_k.delete();
    endtask

    task automatic drive_words(input logic [WW-1:0] w[$], input int gap_pct, input int start_pct);
        foreach (w[i]) begin
            int  gaps;
            int  tmo;
            bit  acc;
            if (gap_pct >= 100) gaps = 1;
            else if (int'($urandom_range(99)) < gap_pct) gaps = $urandom_range(1, 3);
            else gaps = 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = WW'($urandom);
                start    = (int'($urandom_range(99)) < start_pct);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            tmo      = 0;
            do begin
                start = (int'($urandom_range(99)) < start_pct);
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                tmo++;
            end while (!acc && tmo < 50);
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("pending_commits", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_cen_out"}, 64'(cen_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_config_out"}, 64'(config_out), 64'd0);
    endtask

    task automatic full_seq(input int gap_pct, input int start_pct);
        logic [WW-1:0] w[$];
        for (int i = 0; i < NL*WPL; i++) w.push_back(WW'($urandom));
        for (int g = 0; g < NL; g++) exp_q.push_back('{cen: NL'(1) << g, cfg: model(w, g)});
        start_seq();
        drive_words(w, gap_pct, start_pct);
        wait_done();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w[$];
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed first LUT plus cycle-exact timing under continuous valid.
        w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        for (int i = WPL; i < NL*WPL; i++) w.push_back(WW'($urandom));
        exp_q.push_back('{cen: 4'b0001, cfg: 33'h1_0403_0201});
        for (int g = 1; g < NL; g++) exp_q.push_back('{cen: NL'(1) << g, cfg: model(w, g)});
        start_seq();
        drive_words(w, 0, 0);
        wait_done();
        chk("commit_count", 64'(commit_k.size()), 64'(NL));
        for (int g = 0; g < NL && g < commit_k.size(); g++)
            chk("commit_cycle", 64'(commit_k[g]), 64'(6*g + 6));
        chk("done_cycle", 64'(done_k), 64'd25);

        // Alternating valid, with start pulses that must be ignored.
        full_seq(100, 0);
        full_seq(100, 40);

        // Abort after 3 words of LUT 1.
        w.delete();
        for (int i = 0; i < WPL + 3; i++) w.push_back(WW'($urandom));
        exp_q.push_back('{cen: 4'b0001, cfg: model(w, 0)});
        start_seq();
        drive_words(w, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_pending", 64'(exp_q.size()), 64'd0);
        full_seq(0, 0);
        chk("restart_first_cycle", 64'(commit_k.size() > 0 ? commit_k[0] : 0), 64'd6);

        // Randomised traffic.
        for (int r = 0; r < 8; r++) full_seq($urandom_range(0, 60), 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
